decap_input_loader: RTL and testbench

- Sequencer that loads a complete decapsulation job into `decap` from a single 32-bit source memory read port: secret s, then C1, then C0, then poly_g, then a one-cycle `start` pulse.
- Replaces ad-hoc counter-based loading with a handshake-correct controller.
- Sits between the key/ciphertext staging RAM and `decap`.
- Honours C0/C1/poly_g ready backpressure despite the 1-cycle memory read latency.

---
 rtl/decap_input_loader_if.sv | 35 +++
 rtl/decap_input_loader.sv | 119 +++++++++++
 tb/tb_decap_input_loader.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/decap_input_loader_if.sv
// decap_input_loader_if: source-memory read port, decap load streams and job control for decap_input_loader
interface decap_input_loader_if #(
    parameter int ADDR_W = 9,
    parameter int SA_W = 8
);
    logic go;
    logic busy;
    logic loading_done;
    logic mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [31:0] mem_rd_data;
    logic s_wr_en;
    logic [SA_W-1:0] s_addr;
    logic [31:0] s_in;
    logic C1_valid;
    logic C1_ready;
    logic [31:0] C1_in;
    logic C0_valid;
    logic C0_ready;
    logic [31:0] C0_in;
    logic poly_g_valid;
    logic poly_g_ready;
    logic [31:0] poly_g_in;
    logic start;
    modport master (
        input go, mem_rd_data, C1_ready, C0_ready, poly_g_ready,
        output busy, loading_done, mem_rd_en, mem_rd_addr, s_wr_en, s_addr, s_in,
        output C1_valid, C1_in, C0_valid, C0_in, poly_g_valid, poly_g_in, start
    );
    modport slave (
        output go, mem_rd_data, C1_ready, C0_ready, poly_g_ready,
        input busy, loading_done, mem_rd_en, mem_rd_addr, s_wr_en, s_addr, s_in,
        input C1_valid, C1_in, C0_valid, C0_in, poly_g_valid, poly_g_in, start
    );
endinterface

// File: rtl/decap_input_loader.sv
// decap_input_loader: loads s, C1, C0 and poly_g for one decap job from a single 32-bit read port, then pulses start
module decap_input_loader #(
    parameter int parameter_set = 4
) (
    input logic clk,
    input logic rst,
    decap_input_loader_if.master bus
);
    localparam int N = parameter_set == 1 ? 3488 : parameter_set == 2 ? 4608 :
                       parameter_set == 3 ? 6688 : parameter_set == 4 ? 6960 : 8192;
    localparam int M = parameter_set == 1 ? 12 : 13;
    localparam int T = parameter_set == 1 ? 64 : parameter_set == 2 ? 96 : parameter_set == 4 ? 119 : 128;
    localparam int S_WORDS = (N + (32 - N % 32) % 32) / 32;
    localparam int C1_WORDS = 8;
    localparam int C0_WORDS = (M * T + 31) / 32;
    localparam int G_WORDS = (M * (T + 1) + 31) / 32;
    localparam int C1_BASE = S_WORDS;
    localparam int C0_BASE = C1_BASE + C1_WORDS;
    localparam int G_BASE = C0_BASE + C0_WORDS;
    localparam int ADDR_W = $clog2(G_BASE + G_WORDS);
    localparam int SA_W = $clog2(S_WORDS);

    typedef enum logic [2:0] {IDLE, LOAD_S, LOAD_C1, LOAD_C0, LOAD_G, START, DONE} state_t;

    state_t state;
    logic [ADDR_W-1:0] rd_cnt, pop_cnt, words_m1, base;
    logic [1:0] occ;
    logic [31:0] f0, f1;
    logic rd_done, inflight, s_wr, stream, rdy, have, pop, rd, last_rd, last_pop;

    // Stream phases share one 2-entry FIFO; inflight marks a read whose data lands this cycle
    always_comb begin
        stream = state inside {LOAD_C1, LOAD_C0, LOAD_G};
        words_m1 = ADDR_W'(state == LOAD_S ? S_WORDS - 1 : state == LOAD_C1 ? C1_WORDS - 1 :
                           state == LOAD_C0 ? C0_WORDS - 1 : G_WORDS - 1);
        base = ADDR_W'(state == LOAD_C1 ? C1_BASE : state == LOAD_C0 ? C0_BASE : state == LOAD_G ? G_BASE : 0);
        rdy = state == LOAD_C1 ? bus.C1_ready : state == LOAD_C0 ? bus.C0_ready : state == LOAD_G && bus.poly_g_ready;
        have = occ != 2'd0;
        pop = have && rdy;
        rd = state == LOAD_S || (stream && !rd_done && (occ + {1'b0, inflight} < 2'd2 || pop));
        last_rd = rd_cnt == words_m1;
        last_pop = pop && pop_cnt == words_m1;
        bus.mem_rd_en = rd;
        bus.mem_rd_addr = rd ? base + rd_cnt : '0;
        bus.s_wr_en = s_wr;
        bus.s_in = s_wr ? bus.mem_rd_data : '0;
        bus.C1_valid = state == LOAD_C1 && have;
        bus.C0_valid = state == LOAD_C0 && have;
        bus.poly_g_valid = state == LOAD_G && have;
        bus.C1_in = state == LOAD_C1 && have ? f0 : '0;
        bus.C0_in = state == LOAD_C0 && have ? f0 : '0;
        bus.poly_g_in = state == LOAD_G && have ? f0 : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            rd_cnt <= '0;
            pop_cnt <= '0;
            rd_done <= 1'b0;
            inflight <= 1'b0;
            occ <= 2'd0;
            f0 <= '0;
            f1 <= '0;
            s_wr <= 1'b0;
            bus.s_addr <= '0;
            bus.busy <= 1'b0;
            bus.loading_done <= 1'b0;
            bus.start <= 1'b0;
        end else begin
            assert (!(inflight && !pop && occ == 2'd2));
            bus.start <= 1'b0;
            s_wr <= state == LOAD_S;
            bus.s_addr <= SA_W'(rd_cnt);
            inflight <= stream && rd;
            occ <= occ - {1'b0, pop} + {1'b0, inflight};
            if (pop)
                f0 <= f1;
            if (inflight && (occ == 2'd0 || (occ == 2'd1 && pop)))
                f0 <= bus.mem_rd_data;
            if (inflight && occ != 2'd0 && !(occ == 2'd1 && pop))
                f1 <= bus.mem_rd_data;
            if (rd)
                rd_cnt <= rd_cnt + 1'b1;
            if (rd && last_rd)
                rd_done <= 1'b1;
            if (pop)
                pop_cnt <= pop_cnt + 1'b1;
            case (state)
                IDLE, DONE: if (bus.go) begin
                    state <= LOAD_S;
                    rd_cnt <= '0;
                    pop_cnt <= '0;
                    rd_done <= 1'b0;
                    bus.busy <= 1'b1;
                    bus.loading_done <= 1'b0;
                end
                LOAD_S: if (last_rd) begin
                    state <= LOAD_C1;
                    rd_cnt <= '0;
                    rd_done <= 1'b0;
                end
                LOAD_C1, LOAD_C0, LOAD_G: if (last_pop) begin
                    state <= state == LOAD_C1 ? LOAD_C0 : state == LOAD_C0 ? LOAD_G : START;
                    bus.start <= state == LOAD_G;
                    rd_cnt <= '0;
                    pop_cnt <= '0;
                    rd_done <= 1'b0;
                end
                START: begin
                    state <= DONE;
                    bus.busy <= 1'b0;
                    bus.loading_done <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_decap_input_loader.sv
// tb_decap_input_loader: scoreboard bench for sets 4, 1 and 5 with backpressure, mid-job reset and go filtering
module tb_decap_input_loader;
    typedef logic [65:0] w_t;
    typedef struct packed {
        logic mem_rd_en;
        logic [31:0] mem_rd_addr;
        logic s_wr_en;
        logic [31:0] s_addr;
        logic [31:0] s_in;
        logic [2:0] v;
        logic [2:0][31:0] d;
        logic busy;
        logic done;
        logic start;
    } obs_t;

    localparam int PS [3] = '{4, 1, 5};
    localparam int SW [3] = '{218, 109, 256};
    localparam int C0W [3] = '{49, 24, 52};
    localparam int GW [3] = '{49, 25, 53};
    localparam int AW [3] = '{9, 8, 9};
    localparam int SAW [3] = '{8, 7, 8};

    logic clk, rst;
    logic [2:0] go, rdy;
    obs_t ob [3];
    int sel, n_tests, n_fail, exp_rd, outst, starts;
    w_t q[$];
    logic pv, pr;
    logic [31:0] pd;

    function automatic logic [31:0] mem_word(int s, int a);
        return (32'(a) * 32'h9e37_79b9) ^ (32'(s) << 28) ^ 32'h1234_5678;
    endfunction

    task automatic check(string tag, w_t obs, w_t exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : inst
        decap_input_loader_if #(.ADDR_W(AW[g]), .SA_W(SAW[g])) bi ();
        assign bi.go = go[g];
        assign bi.C1_ready = rdy[0];
        assign bi.C0_ready = rdy[1];
        assign bi.poly_g_ready = rdy[2];
        always @(posedge clk)
            bi.mem_rd_data <= bi.mem_rd_en ? mem_word(g, int'(bi.mem_rd_addr)) : 32'hdead_beef;
        decap_input_loader #(.parameter_set(PS[g])) dut (.clk(clk), .rst(rst), .bus(bi.master));
        assign ob[g] = '{mem_rd_en: bi.mem_rd_en, mem_rd_addr: 32'(bi.mem_rd_addr), s_wr_en: bi.s_wr_en,
                         s_addr: 32'(bi.s_addr), s_in: bi.s_in, v: {bi.poly_g_valid, bi.C0_valid, bi.C1_valid},
                         d: {bi.poly_g_in, bi.C0_in, bi.C1_in}, busy: bi.busy, done: bi.loading_done, start: bi.start};
    end

    // Every read, s write and handshake of the active instance is checked against the queued job image
    always @(negedge clk) begin
        obs_t o;
        w_t e;
        logic popn, srd;
        o = ob[sel];
        popn = |(o.v & rdy);
        srd = o.mem_rd_en && o.mem_rd_addr >= 32'(SW[sel]);
        if (o.mem_rd_en) begin
            check("rd_addr", w_t'(o.mem_rd_addr), w_t'(exp_rd));
            exp_rd++;
        end
        if (srd)
            check("rd_rule", w_t'(outst < 2 || popn), w_t'(1));
        if (o.s_wr_en) begin
            e = q.size() != 0 ? q.pop_front() : '1;
            check("s_word", {2'd3, o.s_addr, o.s_in}, e);
        end
        for (int k = 0; k < 3; k++)
            if (o.v[k] && rdy[k]) begin
                e = q.size() != 0 ? q.pop_front() : '1;
                check("stream_word", {2'(k), 32'd0, o.d[k]}, e);
            end
        if (o.v != 3'd0)
            check("phase_iso", w_t'(($countones(o.v) > 1) || o.s_wr_en), w_t'(0));
        if (pv && !pr)
            check("c0_hold", w_t'({o.v[1], o.d[1]}), w_t'({1'b1, pd}));
        pv = o.v[1];
        pr = rdy[1];
        pd = o.d[1];
        outst += (srd ? 1 : 0) - (popn ? 1 : 0);
        if (o.start)
            starts++;
    end

    task automatic arm(int s);
        int b;
        int n [3];
        q.delete();
        exp_rd = 0;
        outst = 0;
        starts = 0;
        pv = 1'b0;
        for (int i = 0; i < SW[s]; i++)
            q.push_back({2'd3, 32'(i), mem_word(s, i)});
        n = '{8, C0W[s], GW[s]};
        b = SW[s];
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < n[k]; i++)
                q.push_back({2'(k), 32'd0, mem_word(s, b + i)});
            b += n[k];
        end
    endtask

    task automatic job(int s, bit rnd, int go_at, int rst_at);
        int cyc;
        sel = s;
        arm(s);
        go[s] = 1'b1;
        @(posedge clk);
        #1 go[s] = 1'b0;
        cyc = 1;
        check("go_accept", w_t'({ob[s].busy, ob[s].done}), w_t'(2'b10));
        while (!ob[s].start && cyc < 3000) begin
            if (cyc == rst_at) begin
                rst = 1'b1;
                #1 check("async_rst", w_t'(|ob[s]), w_t'(0));
                repeat (3) @(posedge clk);
                #1 check("rst_idle", w_t'(|ob[s]), w_t'(0));
                rst = 1'b0;
                return;
            end
            @(posedge clk);
            #1 cyc++;
            rdy[1] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            go[s] = cyc == go_at;
        end
        go[s] = 1'b0;
        rdy[1] = 1'b1;
        check("start_seen", w_t'(ob[s].start), w_t'(1));
        if (!rnd)
            check("latency_ok", w_t'(cyc <= SW[s] + 8 + C0W[s] + GW[s] + 8), w_t'(1));
        @(posedge clk);
        #1 check("done_state", w_t'({ob[s].busy, ob[s].done, ob[s].start}), w_t'(3'b010));
        repeat (20) @(posedge clk);
        #1 check("start_count", w_t'(starts), w_t'(1));
        check("queue_drained", w_t'(q.size()), w_t'(0));
        check("n_reads", w_t'(exp_rd), w_t'(SW[s] + 8 + C0W[s] + GW[s]));
        check("still_done", w_t'({ob[s].busy, ob[s].done, ob[s].mem_rd_en}), w_t'(3'b010));
    endtask

    initial begin
        rst = 1'b1;
        go = 3'b000;
        rdy = 3'b111;
        sel = 0;
        n_tests = 0;
        n_fail = 0;
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++)
            check("rst_outs", w_t'(|ob[s]), w_t'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;
        job(0, 1'b0, 300, 0);
        job(0, 1'b1, 0, 0);
        job(0, 1'b0, 0, 251);
        job(0, 1'b0, 0, 0);
        job(1, 1'b0, 0, 0);
        job(2, 1'b0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
